cb_filter_serial: RTL and testbench
===================================

// Module: cb_filter_serial
// PURPOSE
//  Counting Bloom filter that processes the hash functions serially, one per cycle, over a
//  register-based bucket array; seeded by cb_filter_pkg::cb_seed_t. It is the area-lean
//  counterpart to a parallel filter: it accepts insert/remove/lookup/clear commands over
//  valid/ready and returns hit status. It sits beside ID/address trackers that need set membership.
// PARAMETERS
//  KHashes      3                      number of hash functions (>=1)
//  HashWidth    4                      bucket index width; 2**HashWidth buckets
//  InpWidth     32                     data width to hash (<=32)
//  BucketWidth  4                      counter width per bucket; saturates at 2**BucketWidth-1
//  Seeds        cb_filter_pkg::EgSeeds cb_seed_t [KHashes-1:0], one seed pair per hash
// PORTS
//  clk_i         in   1              clock
//  rst_i         in   1              synchronous reset, active-high
//  req_valid_i   in   1              command valid
//  req_ready_o   out  1              command accepted when valid&&ready
//  req_op_i      in   2              00 lookup, 01 insert, 10 remove, 11 clear
//  req_data_i    in   InpWidth       data to hash (ignored for clear)
//  resp_valid_o  out  1              result valid
//  resp_ready_i  in   1              result consumed when valid&&ready
//  resp_hit_o    out  1              all K buckets of req_data were nonzero before the command
//  usage_o       out  HashWidth+1    number of nonzero buckets
//  empty_o       out  1              usage_o == 0
//  sat_o         out  1              sticky: some increment hit saturation; cleared by clear/reset
// BEHAVIOUR
//  Hash j: x = data ^ Seeds[j].XorSeed[InpWidth-1:0]; x = rotl(x, Seeds[j].PermuteSeed % InpWidth);
//   idx_j = XOR of all HashWidth-bit slices of x (zero-padded at top).
//  FSM IDLE -> BUSY -> RESP -> IDLE. req_ready_o=1 only in IDLE; resp_valid_o=1 only in RESP.
//  IDLE: on accept, latch op/data, j=0, hit accumulator=1; go BUSY (clear goes straight to RESP).
//  BUSY: cycle j reads bucket idx_j, ANDs (bucket!=0) into hit, then in the same cycle writes:
//   insert: +1, saturating (sat_o<=1 if already max); remove: -1, holds at 0; lookup: no write.
//   Duplicate indices across hashes are applied cumulatively (serial RMW sees prior write).
//   After j==KHashes-1 go RESP. Accept at cycle t -> resp_valid_o first high at t+KHashes+1.
//  Clear: all buckets, usage_o and sat_o zeroed in the accept cycle's next edge; resp_hit_o=0.
//  RESP: hold resp_valid_o and resp_hit_o stable until resp_ready_i; then IDLE. No new command
//   accepted in the RESP cycle (no back-to-back bypass); throughput 1 cmd / KHashes+2 cycles.
//  usage_o updated on every 0->1 (+1) and 1->0 (-1) bucket transition, same edge as the write.
//  Remove of never-inserted data is legal (may decrement shared buckets); not detected.
//  Reset (any state, including mid-BUSY): IDLE, all buckets 0, req_ready_o=1, resp_valid_o=0,
//   resp_hit_o=0, usage_o=0, empty_o=1, sat_o=0; the in-flight command is dropped.
//  Inputs req_op_i/req_data_i need only be stable in the accept cycle.
// TESTING
//  Reset -> req_ready_o=1, resp_valid_o=0, empty_o=1, usage_o=0, sat_o=0.
//  Lookup 0x0000_1234 on empty filter, accept at t -> resp_valid_o at t+4, resp_hit_o=0, usage_o=0.
//  Insert 0x0000_1234 then lookup 0x0000_1234 -> hit=1; usage_o = # distinct idx (1..3, per model);
//   then remove 0x0000_1234 -> empty_o=1, usage_o=0.
//  Insert 0xDEAD_BEEF 16x (BucketWidth=4) -> buckets at 15, sat_o=1; 15 removes -> lookup hit=0.
//  Hold resp_ready_i=0 for 10 cycles -> resp_valid/resp_hit stable, req_ready_o=0 throughout.
//  Assert rst_i during BUSY of an insert -> next cycle IDLE, usage_o=0; later lookup hits=0.
//  Clear after 8 random inserts -> resp at t+1, empty_o=1; random ops vs. golden model w/ backpressure.

Source files
------------

// File: rtl/cb_filter_serial.sv
// Serial counting Bloom filter: one hash per cycle, read-modify-write over a
// flop-based bucket array, with a valid/ready command and response handshake.

package cb_filter_pkg;

    typedef struct packed {
        logic [31:0] XorSeed;
        logic [31:0] PermuteSeed;
    } cb_seed_t;

    localparam cb_seed_t [2:0] EgSeeds = '{
        2: '{XorSeed: 32'h0000_F00D, PermuteSeed: 32'd27},
        1: '{XorSeed: 32'h3C96_0F7E, PermuteSeed: 32'd13},
        0: '{XorSeed: 32'hA5A5_1234, PermuteSeed: 32'd5}
    };

    typedef enum logic [1:0] {
        OP_LOOKUP = 2'b00,
        OP_INSERT = 2'b01,
        OP_REMOVE = 2'b10,
        OP_CLEAR  = 2'b11
    } cb_op_e;

endpackage

module cb_filter_serial #(
    parameter int unsigned KHashes     = 3,
    parameter int unsigned HashWidth   = 4,
    parameter int unsigned InpWidth    = 32,
    parameter int unsigned BucketWidth = 4,
    parameter cb_filter_pkg::cb_seed_t [KHashes-1:0] Seeds = cb_filter_pkg::EgSeeds
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [1:0]           req_op_i,
    input  logic [InpWidth-1:0]  req_data_i,
    output logic                 resp_valid_o,
    input  logic                 resp_ready_i,
    output logic                 resp_hit_o,
    output logic [HashWidth:0]   usage_o,
    output logic                 empty_o,
    output logic                 sat_o
);
    import cb_filter_pkg::*;

    localparam int unsigned NumBuckets = 2 ** HashWidth;
    localparam int unsigned NumSlices  = (InpWidth + HashWidth - 1) / HashWidth;
    localparam int unsigned CntWidth   = (KHashes > 1) ? $clog2(KHashes) : 1;
    localparam logic [BucketWidth-1:0] BucketMax = '1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

    state_e                  state, next_state;
    cb_op_e                  op_q;
    logic [InpWidth-1:0]     data_q;
    logic [CntWidth-1:0]     hash_cnt;
    logic                    hit_acc;
    logic                    sat_q;
    logic [HashWidth:0]      usage_q;
    logic [BucketWidth-1:0]  buckets [NumBuckets];
    logic [HashWidth-1:0]    bucket_idx;
    logic [BucketWidth-1:0]  cur_bucket;
    logic                    last_hash;

    // Seed XOR, rotate left, then fold all HashWidth-bit slices together.
    function automatic logic [HashWidth-1:0] hash_idx(input logic [InpWidth-1:0] data,
                                                      input cb_seed_t seed);
        logic [InpWidth-1:0]            x;
        logic [NumSlices*HashWidth-1:0] padded;
        logic [HashWidth-1:0]           acc;
        int unsigned                    amt;
        amt = seed.PermuteSeed % InpWidth;
        x   = data ^ seed.XorSeed[InpWidth-1:0];
        if (amt != 0) x = (x << amt) | (x >> (InpWidth - amt));
        padded = '0;
        padded[InpWidth-1:0] = x;
        acc = '0;
        for (int i = 0; i < NumSlices; i++) acc ^= padded[i*HashWidth +: HashWidth];
        return acc;
    endfunction

    assign bucket_idx = hash_idx(data_q, Seeds[hash_cnt]);
    assign cur_bucket = buckets[bucket_idx];
    assign last_hash  = (hash_cnt == CntWidth'(KHashes - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        next_state   = state;
        req_ready_o  = 1'b0;
        resp_valid_o = 1'b0;
        case (state)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) next_state = (cb_op_e'(req_op_i) == OP_CLEAR) ? RESP : BUSY;
            end
            BUSY: if (last_hash) next_state = RESP;
            RESP: begin
                resp_valid_o = 1'b1;
                if (resp_ready_i) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: the buckets are plain flops rather than a RAM, so reset clears them directly.
            for (int i = 0; i < NumBuckets; i++) buckets[i] <= '0;
            op_q     <= OP_LOOKUP;
            data_q   <= '0;
            hash_cnt <= '0;
            hit_acc  <= 1'b0;
            sat_q    <= 1'b0;
            usage_q  <= '0;
        end else begin
            // NOTE: sequential state uses <= so every read here sees the pre-edge value.
            case (state)
                IDLE: if (req_valid_i) begin
                    op_q     <= cb_op_e'(req_op_i);
                    data_q   <= req_data_i;
                    hash_cnt <= '0;
                    hit_acc  <= 1'b1;
                    if (cb_op_e'(req_op_i) == OP_CLEAR) begin
                        for (int i = 0; i < NumBuckets; i++) buckets[i] <= '0;
                        usage_q <= '0;
                        sat_q   <= 1'b0;
                        hit_acc <= 1'b0;
                    end
                end
                BUSY: begin
                    hit_acc  <= hit_acc & (cur_bucket != '0);
                    hash_cnt <= hash_cnt + 1'b1;
                    case (op_q)
                        OP_INSERT: begin
                            if (cur_bucket == BucketMax) begin
                                sat_q <= 1'b1;
                            end else begin
                                buckets[bucket_idx] <= cur_bucket + 1'b1;
                                if (cur_bucket == '0) usage_q <= usage_q + 1'b1;
                            end
                        end
                        OP_REMOVE: begin
                            if (cur_bucket != '0) begin
                                buckets[bucket_idx] <= cur_bucket - 1'b1;
                                if (cur_bucket == BucketWidth'(1)) usage_q <= usage_q - 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign resp_hit_o = resp_valid_o & hit_acc;
    assign usage_o    = usage_q;
    assign empty_o    = (usage_q == '0);
    assign sat_o      = sat_q;

endmodule

// File: tb/tb_cb_filter_serial.sv
// Directed and random checks of cb_filter_serial against a behavioural bucket
// model, with expected responses queued at issue and compared on response.

module tb_cb_filter_serial;
    import cb_filter_pkg::*;

    localparam int K = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [31:0] req_data = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic        resp_hit;
    logic [4:0]  usage;
    logic        empty;
    logic        sat;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       hit;
        logic [4:0] usage;
        logic       sat;
        int         latency;
    } exp_t;

    exp_t sb[$];
    int   mb[16];
    logic msat = 1'b0;

    always #5 clk = ~clk;

    cb_filter_serial dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_op_i    (req_op),
        .req_data_i  (req_data),
        .resp_valid_o(resp_valid),
        .resp_ready_i(resp_ready),
        .resp_hit_o  (resp_hit),
        .usage_o     (usage),
        .empty_o     (empty),
        .sat_o       (sat)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Bit-level model of the hash: rotate by moving each bit, fold by bit position.
    function automatic logic [3:0] m_idx(input logic [31:0] d, input int j);
        logic [31:0] x;
        logic [31:0] r;
        logic [3:0]  f;
        int          sh;
        x  = d ^ EgSeeds[j].XorSeed;
        sh = int'(EgSeeds[j].PermuteSeed % 32);
        for (int b = 0; b < 32; b++) r[(b + sh) % 32] = x[b];
        f = '0;
        for (int b = 0; b < 32; b++) f[b % 4] = f[b % 4] ^ r[b];
        return f;
    endfunction

    function automatic logic [4:0] m_usage();
        int n = 0;
        for (int i = 0; i < 16; i++) if (mb[i] != 0) n++;
        return 5'(n);
    endfunction

    function automatic exp_t m_apply(input logic [1:0] op, input logic [31:0] d);
        exp_t e;
        e.hit = 1'b1;
        if (op == 2'b11) begin
            for (int i = 0; i < 16; i++) mb[i] = 0;
            msat = 1'b0;
            e.hit = 1'b0;
            e.latency = 0;
        end else begin
            for (int j = 0; j < K; j++) begin
                int i = int'(m_idx(d, j));
                if (mb[i] == 0) e.hit = 1'b0;
                if (op == 2'b01) begin
                    if (mb[i] == 15) msat = 1'b1;
                    else mb[i] = mb[i] + 1;
                end else if (op == 2'b10 && mb[i] > 0) begin
                    mb[i] = mb[i] - 1;
                end
            end
            e.latency = K;
        end
        e.usage = m_usage();
        e.sat   = msat;
        return e;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 16; i++) mb[i] = 0;
        msat = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".req_ready"},  32'(req_ready),  32'd1);
        check({tag, ".resp_valid"}, 32'(resp_valid), 32'd0);
        check({tag, ".resp_hit"},   32'(resp_hit),   32'd0);
        check({tag, ".usage"},      32'(usage),      32'd0);
        check({tag, ".empty"},      32'(empty),      32'd1);
        check({tag, ".sat"},        32'(sat),        32'd0);
    endtask

    // Issue one command at a negedge, wait for the response, hold it for
    // 'stall' cycles, then compare against the queued expectation.
    task automatic run_cmd(input string tag, input logic [1:0] op, input logic [31:0] d,
                           input int stall);
        exp_t e;
        int   n;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, ".ready_wait"}, 32'(req_ready), 32'd1);
        sb.push_back(m_apply(op, d));
        req_valid = 1'b1;
        req_op    = op;
        req_data  = d;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_op    = 2'($urandom);
        req_data  = $urandom;
        n = 0;
        while (!resp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        e = sb.pop_front();
        check({tag, ".latency"}, 32'(n), 32'(e.latency));
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check({tag, ".hold_valid"}, 32'(resp_valid), 32'd1);
            check({tag, ".hold_hit"},   32'(resp_hit),   32'(e.hit));
            check({tag, ".hold_ready"}, 32'(req_ready),  32'd0);
        end
        check({tag, ".hit"},   32'(resp_hit), 32'(e.hit));
        check({tag, ".usage"}, 32'(usage),    32'(e.usage));
        check({tag, ".empty"}, 32'(empty),    32'(e.usage == 0));
        check({tag, ".sat"},   32'(sat),      32'(e.sat));
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] pool [8];
        int          n;

        m_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_idle("reset");

        run_cmd("lookup_empty", 2'b00, 32'h0000_1234, 0);
        run_cmd("insert_1234",  2'b01, 32'h0000_1234, 0);
        run_cmd("lookup_1234",  2'b00, 32'h0000_1234, 0);
        run_cmd("remove_1234",  2'b10, 32'h0000_1234, 0);
        check("remove_1234.empty_after", 32'(empty), 32'd1);

        for (int i = 0; i < 16; i++) run_cmd("sat_insert", 2'b01, 32'hDEAD_BEEF, 0);
        check("sat_insert.sat_set", 32'(sat), 32'd1);
        for (int i = 0; i < 15; i++) run_cmd("sat_remove", 2'b10, 32'hDEAD_BEEF, 0);
        run_cmd("sat_lookup", 2'b00, 32'hDEAD_BEEF, 0);

        run_cmd("bp_insert", 2'b01, 32'h0BAD_CAFE, 0);
        run_cmd("bp_lookup", 2'b00, 32'h0BAD_CAFE, 10);

        // Reset while an insert is in its first hash cycle.
        req_valid = 1'b1;
        req_op    = 2'b01;
        req_data  = 32'h1357_9BDF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("midbusy.req_ready_busy", 32'(req_ready), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_reset();
        check_idle("midbusy");
        run_cmd("midbusy_lookup", 2'b00, 32'h1357_9BDF, 0);
        run_cmd("midbusy_lookup_old", 2'b00, 32'h0BAD_CAFE, 0);

        for (int i = 0; i < 8; i++) begin
            pool[i] = $urandom;
            run_cmd("rand_insert", 2'b01, pool[i], 0);
        end
        run_cmd("clear", 2'b11, 32'hFFFF_FFFF, 0);
        check("clear.empty_after", 32'(empty), 32'd1);

        for (int i = 0; i < 40; i++) begin
            logic [1:0] op;
            n  = $urandom_range(0, 19);
            op = (n < 8) ? 2'b01 : (n < 13) ? 2'b00 : (n < 19) ? 2'b10 : 2'b11;
            run_cmd("random", op, pool[$urandom_range(0, 7)], $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
